// File: rtl/xpb_gen_pkg.sv
// Shared defaults and state encoding for the XPB lookup-table generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package xpb_gen_pkg;

    localparam int DEF_WIDTH      = 1024;
    localparam int DEF_DIGIT_BITS = 5;
    localparam int DEF_SHIFT_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POW  = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/xpb_modadd.sv
// Combinational modular add: (a + b) mod m, with a, b < m.
// Latency: 0 cycles, one WIDTH+1 add plus compare/subtract.
// Backpressure: none (pure combinational).
module xpb_modadd
    import xpb_gen_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] sum
);

    // Carry bit is kept so a sum at or above 2^WIDTH still compares correctly.
    logic [WIDTH:0] raw;
    logic [WIDTH:0] red;

    assign raw = {1'b0, a} + {1'b0, b};
    assign red = raw - {1'b0, m};

    // Both operands are already reduced, so one conditional subtract is enough.
    assign sum = (raw >= {1'b0, m}) ? red[WIDTH-1:0] : raw[WIDTH-1:0];

endmodule

// File: rtl/xpb_table_gen.sv
// Builds B = 2^S mod M by modular doubling, then streams j*B mod M for every table index.
// Latency: S cycles of doubling, then one entry per cycle; done one cycle after the last entry.
// Backpressure: wr_valid/wr_addr/wr_data hold while wr_ready is low; the stream pauses.
module xpb_table_gen
    import xpb_gen_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DIGIT_BITS = DEF_DIGIT_BITS,
    parameter int SHIFT_W    = DEF_SHIFT_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      modulus,
    input  logic [SHIFT_W-1:0]    shift,
    output logic                  busy,
    output logic                  done,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [DIGIT_BITS-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data
);

    localparam logic [DIGIT_BITS-1:0] LAST_ADDR = '1;

    state_t             state;
    logic [WIDTH-1:0]   m_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   acc;
    logic [SHIFT_W-1:0] cnt;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH-1:0]   add_sum;

    // Single adder: doubles acc while building B, adds B while stepping entries.
    always_comb begin
        add_b = acc;
        if (state == EMIT) begin
            add_b = b_reg;
        end
    end

    xpb_modadd #(
        .WIDTH (WIDTH)
    ) u_modadd (
        .a   (acc),
        .b   (add_b),
        .m   (m_reg),
        .sum (add_sum)
    );

    // Control FSM with all outputs registered; wr_data only changes on a fire.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            m_reg    <= '0;
            b_reg    <= '0;
            acc      <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_reg <= modulus;
                        cnt   <= shift;
                        busy  <= 1'b1;
                        if (shift == '0) begin
                            // 2^0 mod M is 1 for any M > 1; skip straight to streaming.
                            b_reg    <= WIDTH'(1);
                            acc      <= '0;
                            wr_addr  <= '0;
                            wr_data  <= '0;
                            wr_valid <= 1'b1;
                            state    <= EMIT;
                        end else begin
                            acc   <= WIDTH'(1);
                            state <= POW;
                        end
                    end
                end

                POW: begin
                    cnt <= cnt - SHIFT_W'(1);
                    if (cnt == SHIFT_W'(1)) begin
                        // Last doubling lands directly in B; entry 0 is always zero.
                        b_reg    <= add_sum;
                        acc      <= '0;
                        wr_addr  <= '0;
                        wr_data  <= '0;
                        wr_valid <= 1'b1;
                        state    <= EMIT;
                    end else begin
                        acc <= add_sum;
                    end
                end

                EMIT: begin
                    if (wr_ready) begin
                        if (wr_addr == LAST_ADDR) begin
                            // Final entry accepted: no wrap back to entry 0.
                            acc      <= '0;
                            wr_valid <= 1'b0;
                            wr_addr  <= '0;
                            wr_data  <= '0;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= DONE;
                        end else begin
                            acc     <= add_sum;
                            wr_data <= add_sum;
                            wr_addr <= wr_addr + DIGIT_BITS'(1);
                        end
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed bench for xpb_table_gen with a golden j*2^S mod M scoreboard.
// Latency: checks first-valid and done cycles against the fixed schedule.
// Backpressure: random wr_ready stalls with hold-stability checks.
module tb_xpb_table_gen;

    localparam int W  = 1024;
    localparam int W2 = 2 * W;
    localparam int DB = 5;
    localparam int SW = 16;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  modulus;
    logic [SW-1:0] shift;
    logic          busy;
    logic          done;
    logic          wr_valid;
    logic          wr_ready;
    logic [DB-1:0] wr_addr;
    logic [W-1:0]  wr_data;

    int checks = 0;
    int errors = 0;

    logic [W-1:0]  exp_d[$];
    logic [DB-1:0] exp_a[$];
    logic [W-1:0]  got[N];

    always #5 clk = ~clk;

    xpb_table_gen #(
        .WIDTH      (W),
        .DIGIT_BITS (DB),
        .SHIFT_W    (SW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .modulus  (modulus),
        .shift    (shift),
        .busy     (busy),
        .done     (done),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs[127:0], exp[127:0]);
        end
    endtask

    // One table generation: golden entries queued at start, compared on each fire.
    task automatic run_table(input logic [W-1:0] m, input int s, input int stall_pct,
                             input int pulse_at, input int rst_at);
        logic [W2-1:0] mm, p, bb, jj, e;
        logic [DB-1:0] h_a, ea;
        logic [W-1:0]  h_d, ed;
        int            cyc, fires, first_v, done_cyc;
        bit            hold, fire, pulsed, seen, finished;

        mm = {{W{1'b0}}, m};
        p  = W2'(1) << s;
        bb = p % mm;
        exp_a.delete();
        exp_d.delete();
        for (int j = 0; j < N; j++) begin
            jj = W2'(j);
            e  = (jj * bb) % mm;
            exp_a.push_back(DB'(j));
            exp_d.push_back(e[W-1:0]);
        end

        @(negedge clk);
        modulus  = m;
        shift    = SW'(s);
        start    = 1'b1;
        wr_ready = 1'b0;
        chk("idle_busy", W'(busy), W'(0));
        chk("idle_valid", W'(wr_valid), W'(0));

        cyc = 0; fires = 0; first_v = -1; done_cyc = -1;
        hold = 1'b0; pulsed = 1'b0; finished = 1'b0;
        h_a = '0; h_d = '0;

        while (!finished && cyc < s + 2000) begin
            @(negedge clk);
            cyc++;
            start   = 1'b0;
            modulus = m;
            shift   = SW'(s);
            if (cyc == 1) chk("busy_rise", W'(busy), W'(1));
            if (hold) begin
                chk("hold_valid", W'(wr_valid), W'(1));
                chk("hold_addr", W'(wr_addr), W'(h_a));
                chk("hold_data", wr_data, h_d);
            end
            if (done) begin
                done_cyc = cyc;
                chk("done_busy", W'(busy), W'(0));
                chk("done_valid", W'(wr_valid), W'(0));
                finished = 1'b1;
            end else begin
                if (wr_valid && first_v < 0) first_v = cyc;
                if (rst_at >= 0 && wr_valid && wr_addr == DB'(rst_at)) begin
                    rst      = 1'b1;
                    wr_ready = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    chk("rst_busy", W'(busy), W'(0));
                    chk("rst_done", W'(done), W'(0));
                    chk("rst_valid", W'(wr_valid), W'(0));
                    chk("rst_addr", W'(wr_addr), W'(0));
                    chk("rst_data", wr_data, W'(0));
                    seen = 1'b0;
                    repeat (40) begin
                        @(negedge clk);
                        if (done || wr_valid) seen = 1'b1;
                    end
                    chk("rst_no_done", W'(seen), W'(0));
                    return;
                end
                if (pulse_at >= 0 && !pulsed && wr_valid && wr_addr == DB'(pulse_at)) begin
                    start   = 1'b1;
                    modulus = W'(7);
                    shift   = SW'(3);
                    pulsed  = 1'b1;
                end
                wr_ready = (stall_pct > 0) ? ($urandom_range(99, 0) >= stall_pct) : 1'b1;
                fire = wr_valid && wr_ready;
                if (fire) begin
                    if (exp_a.size() == 0) begin
                        chk("extra_fire", W'(1), W'(0));
                    end else begin
                        ea = exp_a.pop_front();
                        ed = exp_d.pop_front();
                        chk("entry_addr", W'(wr_addr), W'(ea));
                        chk("entry_data", wr_data, ed);
                        got[wr_addr] = wr_data;
                        fires++;
                    end
                end
                hold = wr_valid && !fire;
                h_a  = wr_addr;
                h_d  = wr_data;
            end
        end

        chk("done_seen", W'(done_cyc >= 0), W'(1));
        chk("fire_count", W'(fires), W'(N));
        chk("queue_empty", W'(exp_a.size()), W'(0));
        chk("first_valid_cycle", W'(first_v), W'(s + 1));
        if (stall_pct == 0) chk("done_cycle", W'(done_cyc), W'(s + N + 1));
        @(negedge clk);
        chk("done_one_cycle", W'(done), W'(0));
        chk("idle_after", W'(busy), W'(0));
    endtask

    initial begin
        logic [W-1:0] rm;

        rst      = 1'b1;
        start    = 1'b0;
        modulus  = '0;
        shift    = '0;
        wr_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_done", W'(done), W'(0));
        chk("reset_valid", W'(wr_valid), W'(0));
        chk("reset_addr", W'(wr_addr), W'(0));
        chk("reset_data", wr_data, W'(0));
        rst = 1'b0;

        // M=13, S=0: entries are j mod 13.
        run_table(W'(13), 0, 0, -1, -1);
        chk("m13s0_e1", got[1], W'(1));
        chk("m13s0_e13", got[13], W'(0));
        chk("m13s0_e31", got[31], W'(5));

        // M=13, S=4: B = 3.
        run_table(W'(13), 4, 0, -1, -1);
        chk("m13s4_b", got[1], W'(3));
        chk("m13s4_e5", got[5], W'(2));
        chk("m13s4_e31", got[31], W'(2));

        // M=0xFFF1, S=16 with random stalls: B = 15.
        run_table(W'(16'hFFF1), 16, 40, -1, -1);
        chk("fff1_b", got[1], W'(15));
        chk("fff1_e31", got[31], W'(465));

        // Start pulsed mid-stream must not disturb the table or timing.
        run_table(W'(13), 4, 0, 5, -1);
        chk("pulse_e31", got[31], W'(2));

        // Reset at entry 10, then a clean regeneration.
        run_table(W'(16'hFFF1), 16, 0, -1, 10);
        run_table(W'(16'hFFF1), 16, 0, -1, -1);
        chk("regen_e31", got[31], W'(465));

        // Full-width random odd modulus with the top bit set, S=1024.
        rm = '0;
        for (int k = 0; k < W / 32; k++) rm[k*32 +: 32] = $urandom();
        rm[W-1] = 1'b1;
        rm[0]   = 1'b1;
        run_table(rm, 1024, 20, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/xpb_table_gen.md
# xpb_table_gen

Runtime generator for the XPB reduction lookup tables consumed by the modular-squaring datapath. For a latched modulus M and shift S, it computes base B = 2^S mod M by repeated modular doubling. It then streams the 2^DIGIT_BITS table entries j·B mod M (j = 0..31 for the default) over a valid/ready write port into the table RAM that the `xpb_*` lookups read. This replaces hard-coded ROM contents when the modulus changes.

## Interface
- WIDTH, 1024, modulus/entry width in bits
- DIGIT_BITS, 5, table index width; entry count = 2^DIGIT_BITS
- SHIFT_W, 16, width of shift input
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; honoured only in IDLE
- modulus  in  WIDTH  M, sampled on accepted start; must be odd, > 1
- shift  in  SHIFT_W  S, sampled on accepted start
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse after last entry accepted
- wr_valid  out  1  entry present on wr_addr/wr_data
- wr_ready  in  1  sink accepts entry when high with wr_valid
- wr_addr  out  DIGIT_BITS  entry index j
- wr_data  out  WIDTH  j·B mod M

## Operation
- States: IDLE, POW, EMIT, DONE.
- IDLE: all outputs 0. start=1 latches M, S; acc <= 1; cnt <= S; go POW (or EMIT directly if S=0).
- POW: each cycle acc <= (2·acc) mod M, cnt <= cnt-1; when cnt reaches 0, B <= acc, acc <= 0, wr_addr <= 0, go EMIT.
- Modular add rule: t = a + b computed at WIDTH+1 bits; result = t − M if t ≥ M, else t. Inputs are always < M, so one conditional subtract suffices. Doubling uses a = b = acc.
- EMIT: wr_valid=1, wr_data=acc, wr_addr=j. On fire (wr_valid & wr_ready): acc <= (acc + B) mod M, j <= j+1. On fire with j = 2^DIGIT_BITS−1, go DONE; no wrap to entry 0 is ever emitted.
- DONE: done=1 for one cycle, busy drops, go IDLE.
- start while not IDLE: ignored; latched M/S unchanged.
- Entry 0 is always 0. Entry 1 is B = 2^S mod M (B = 1 when S = 0, M > 1).
- rst in any state: next cycle IDLE, busy=done=wr_valid=0, wr_addr=0, wr_data=0. No partial-table completion is signalled.

## Timing
- Accepted start at cycle 0. POW occupies cycles 1..S. First wr_valid at cycle S+1 (cycle 1 when S=0).
- With wr_ready held high: one entry per cycle, entry j at cycle S+1+j. done at cycle S+1+2^DIGIT_BITS. Back in IDLE and able to accept start one cycle later.
- Backpressure: while wr_valid=1 and wr_ready=0, wr_valid, wr_addr and wr_data hold stable. wr_valid never drops before fire.
- wr_ready in non-EMIT states: ignored.
- Critical path: one WIDTH+1 add plus compare/subtract. Registered output on wr_data, acc and wr_addr; no combinational path from wr_ready to wr_data.

## Structure
- Package xpb_gen_pkg: WIDTH, DIGIT_BITS, SHIFT_W defaults; state enum {IDLE, POW, EMIT, DONE}.
- Sub-module xpb_modadd: combinational (a + b) mod M at WIDTH bits. One instance, muxed between doubling (b=acc) and stepping (b=B).
- Top: FSM, acc/B/M/cnt/j registers, handshake.

## Test plan
- WIDTH=8, M=13, S=0, wr_ready=1: 32 entries j mod 13. Entry 13 = 0, entry 31 = 5. done at cycle 33.
- WIDTH=8, M=13, S=4: B = 3. Entry 5 = 2, entry 31 = 2. First wr_valid at cycle 5.
- WIDTH=16, M=0xFFF1, S=16: B = 15, entry 31 = 465. Random wr_ready stalls: data stable across stalls, 32 fires, addresses 0..31 in order.
- start pulsed during EMIT: ignored, table unchanged. rst asserted at entry 10: outputs 0 next cycle, no done. A fresh start afterwards regenerates from entry 0.
- WIDTH=1024, random odd M, S=1024: all 32 entries match a software golden model of j·2^1024 mod M.
